// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Requester ids, response-phase states and the default debug wait limit.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_C = 2'd1,
    RESP_D = 2'd2
  } resp_state_e;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DBG  = 1'b1
  } req_id_e;

  localparam int MAX_WAIT_DEF = 4;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating count of cycles the debug port has been passed over.
// at_limit lets debug pre-empt the core once the bound is reached.
module dmem_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic waiting,
  input  logic granted,
  output logic at_limit
);

  logic [3:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (granted || !waiting) begin
      cnt <= '0;
    end else if (cnt != 4'(MAX_WAIT)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_limit = (cnt == 4'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter for the single-ported synchronous data memory.
// Core has priority; debug has a bounded wait; one-cycle ack with range check.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [31:0]       c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic              c_err,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  resp_state_e       state_q, state_d;
  logic              c_elig, d_elig, gnt_c, gnt_d, gnt, at_limit;
  req_id_e           sel;
  logic [31:0]       g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              g_we, g_in_range;
  logic              err_p1, rd_p1;

  dmem_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .waiting  (d_req),
    .granted  (gnt_d),
    .at_limit (at_limit)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      err_p1  <= 1'b0;
      rd_p1   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_p1  <= gnt & ~g_in_range;
      rd_p1   <= gnt & ~g_we & g_in_range;
    end
  end

  // A port in its response phase cannot be re-granted on a still-high req.
  always_comb begin
    c_elig  = c_req & (state_q != RESP_C);
    d_elig  = d_req & (state_q != RESP_D);
    gnt_d   = d_elig & (at_limit | ~c_elig);
    gnt_c   = c_elig & ~gnt_d;
    state_d = IDLE;
    if (gnt_c) begin
      state_d = RESP_C;
    end else if (gnt_d) begin
      state_d = RESP_D;
    end
  end

  assign gnt        = gnt_c | gnt_d;
  assign sel        = gnt_d ? REQ_DBG : REQ_CORE;
  assign g_addr     = (sel == REQ_DBG) ? d_addr  : c_addr;
  assign g_wdata    = (sel == REQ_DBG) ? d_wdata : c_wdata;
  assign g_we       = (sel == REQ_DBG) ? d_we    : c_we;
  assign g_in_range = (g_addr[31:ADDR_W] == '0);

  always_comb begin
    mem_we    = gnt & g_we & g_in_range & RST_N;
    mem_addr  = gnt ? g_addr[ADDR_W-1:0] : '0;
    mem_wdata = gnt ? g_wdata : '0;
    c_ack     = (state_q == RESP_C);
    d_ack     = (state_q == RESP_D);
    c_err     = c_ack & err_p1;
    d_err     = d_ack & err_p1;
    c_rdata   = (c_ack & rd_p1) ? mem_rdata : '0;
    d_rdata   = (d_ack & rd_p1) ? mem_rdata : '0;
  end

endmodule
